// File: rtl/dp_matrix_pkg.sv
// Shared types and sizing for the constellation-histogram measurement scheduler.
package dp_matrix_pkg;

    localparam int MAT_DIM_DEF = 9;
    localparam int CNT_W_DEF   = 9;
    localparam int ADDR_W      = 4;
    localparam int NUM_CELLS   = MAT_DIM_DEF * MAT_DIM_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_FLUSH,
        S_READOUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/dp_matrix_rd_walker.sv
// Row-major readout address generator for the I/Q matrix: column fastest, wraps
// back to (0,0) after the last cell and flags the last cell combinationally.
module dp_matrix_rd_walker
    import dp_matrix_pkg::*;
#(
    parameter int MAT_DIM = MAT_DIM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              last
);

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAT_DIM - 1);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == MAX_IDX) && (col_q == MAX_IDX);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == MAX_IDX) begin
                col_d = '0;
                row_d = last ? '0 : row_q + ADDR_W'(1);
            end else begin
                col_d = col_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/dp_matrix_scheduler.sv
// Sequences one histogram measurement: clear, gate WINDOW_LEN samples, flush, stream
// all cells out. Optional sat_flag output enabled by DP_MATRIX_SCHED_SAT_FLAG_EN.
//
// state     | meaning
// IDLE      | waiting for start
// CLEAR     | acc_clear pulsed for one cycle
// ACCUM     | sample_valid forwarded to the accumulator until the window is full
// FLUSH     | input-stage latency drains, FLUSH_CYCLES cycles
// READOUT   | cells streamed row-major over valid/ready
// DONE      | one-cycle done pulse
module dp_matrix_scheduler
    import dp_matrix_pkg::*;
#(
    parameter int WINDOW_LEN   = 256,
    parameter int MAT_DIM      = MAT_DIM_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    output logic              acc_clear,
    output logic              acc_en,
    output logic [ADDR_W-1:0] rd_row,
    output logic [ADDR_W-1:0] rd_col,
    input  logic [CNT_W-1:0]  cell_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sample_cnt
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
    ,
    output logic              sat_flag
`endif
);

    localparam logic [15:0] WIN_LEN = 16'(WINDOW_LEN);
    localparam logic [15:0] WIN_M1  = 16'(WINDOW_LEN - 1);
    localparam logic [3:0]  FLUSH_N = 4'(FLUSH_CYCLES);

    state_t             state_q, state_d;
    logic [15:0]        sample_cnt_q, sample_cnt_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               issued_q, issued_d;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
    logic               sat_q, sat_d;
`endif

    logic load;
    logic rd_last;
    logic walk_clr;

    // abort must silence every strobe in the very cycle it is seen
    assign acc_en     = (state_q == S_ACCUM) && sample_valid && !abort;
    assign acc_clear  = (state_q == S_CLEAR) && !abort;
    assign load       = (state_q == S_READOUT) && !issued_q && (!out_valid_q || out_ready) && !abort;
    assign out_valid  = out_valid_q && !abort;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign sample_cnt = sample_cnt_q;
    assign walk_clr   = abort || (state_q != S_READOUT);
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
    assign sat_flag   = sat_q;
`endif

    dp_matrix_rd_walker #(
        .MAT_DIM (MAT_DIM)
    ) u_walker (
        .clk  (clk),
        .rst  (rst),
        .clr  (walk_clr),
        .adv  (load),
        .row  (rd_row),
        .col  (rd_col),
        .last (rd_last)
    );

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        issued_d     = issued_q;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
        sat_d        = sat_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            issued_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d      = S_CLEAR;
                        sample_cnt_d = '0;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
                        sat_d        = 1'b0;
`endif
                    end
                end
                S_CLEAR: state_d = S_ACCUM;
                S_ACCUM: begin
                    if (sample_valid) begin
                        sample_cnt_d = (sample_cnt_q >= WIN_LEN) ? WIN_LEN : sample_cnt_q + 16'd1;
                        if (sample_cnt_q >= WIN_M1) begin
                            state_d     = (FLUSH_CYCLES == 0) ? S_READOUT : S_FLUSH;
                            flush_cnt_d = FLUSH_N;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q <= 4'd1) begin
                        state_d     = S_READOUT;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                S_READOUT: begin
                    if (load) begin
                        out_valid_d = 1'b1;
                        out_data_d  = cell_data;
                        out_last_d  = rd_last;
                        if (rd_last) issued_d = 1'b1;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
                        if (cell_data == '1) sat_d = 1'b1;
`endif
                    end else if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                    if (out_valid_q && out_ready && out_last_q) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        issued_d    = 1'b0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            flush_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            issued_q     <= 1'b0;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            issued_q     <= issued_d;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
            sat_q        <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_dp_matrix_scheduler.sv
// Directed bench for dp_matrix_scheduler with a behavioural 9x9 accumulator model.
module tb_dp_matrix_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, abort, sample_valid, out_ready;
    logic        acc_clear, acc_en, out_valid, out_last, busy, done;
    logic [3:0]  rd_row, rd_col;
    logic [8:0]  cell_data, out_data;
    logic [15:0] sample_cnt;
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
    logic        sat_flag;
`endif

    bit          addr_mode = 1'b0;
    bit          force44   = 1'b0;
    logic [8:0]  mat [0:80];
    int          samp_idx = 0;
    int          tests_run = 0;
    int          fails = 0;

    typedef struct {
        int n_clr, n_en, last_en, first_val, nb, gap, data_err, last_err;
        int stab_err, sv_err, done_cyc, fin_cnt, cnt_at_clr;
        bit fin, sat_done, sat_clr;
    } meas_t;

    always #5 clk = ~clk;

    dp_matrix_scheduler #(
        .WINDOW_LEN   (256),
        .MAT_DIM      (9),
        .CNT_W        (9),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .sample_valid (sample_valid),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .cell_data    (cell_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .sample_cnt   (sample_cnt)
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
        ,
        .sat_flag     (sat_flag)
`endif
    );

    // Sample k of a window lands in cell k % 81
    always @(posedge clk) begin
        if (acc_clear) begin
            for (int i = 0; i < 81; i++) mat[i] <= '0;
            samp_idx <= 0;
        end else if (acc_en) begin
            mat[samp_idx % 81] <= mat[samp_idx % 81] + 9'd1;
            samp_idx <= samp_idx + 1;
        end
    end

    always_comb begin
        cell_data = '0;
        if (rd_row < 4'd9 && rd_col < 4'd9) begin
            if (addr_mode)
                cell_data = 9'(int'(rd_row) * 9 + int'(rd_col) + 100);
            else if (force44 && rd_row == 4'd4 && rd_col == 4'd4)
                cell_data = 9'd511;
            else
                cell_data = mat[int'(rd_row) * 9 + int'(rd_col)];
        end
    end

    task automatic run_measure(input bit rand_ready, input bit toggle_sv, input bit start_in_ro,
                               output meas_t m);
        bit pv, pr, pl;
        logic [8:0] pd;
        int last_beat, expd;
        m = '{default: 0};
        m.first_val = -1;
        m.last_en = -1;
        pv = 0; pr = 0; pl = 0; pd = '0; last_beat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start        = (cyc == 0) || (start_in_ro && pv);
            sample_valid = toggle_sv ? (cyc % 2 == 0) : 1'b1;
            out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            abort        = 1'b0;
            #1;
            if (cyc == 1) begin
                m.cnt_at_clr = int'(sample_cnt);
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
                m.sat_clr = sat_flag;
`endif
            end
            if (acc_clear) m.n_clr++;
            if (acc_en) begin
                m.n_en++;
                m.last_en = cyc;
                if (!sample_valid) m.sv_err++;
            end
            if (out_valid) begin
                if (m.first_val < 0) m.first_val = cyc;
                if (pv && !pr && (out_data !== pd || out_last !== pl)) m.stab_err++;
            end
            if (out_valid && out_ready) begin
                expd = addr_mode ? 100 + m.nb : ((m.nb < 13) ? 4 : 3);
                if (int'(out_data) != expd) m.data_err++;
                if (out_last !== (m.nb == 80)) m.last_err++;
                if (m.nb > 0 && cyc != last_beat + 1) m.gap++;
                last_beat = cyc;
                m.nb++;
            end
            if (done) begin
                m.fin = 1;
                m.done_cyc = cyc;
                m.fin_cnt = int'(sample_cnt);
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
                m.sat_done = sat_flag;
`endif
                break;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; sample_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({acc_clear, acc_en, out_valid, out_last, busy, done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {acc_clear, acc_en, out_valid, out_last, busy, done});
        end
        tests_run++;
        if ({rd_row, rd_col} !== 8'h00) begin
            fails++; $display("FAIL reset_addr: got %h expected 00", {rd_row, rd_col});
        end
        tests_run++;
        if (sample_cnt !== 16'd0 || out_data !== 9'd0) begin
            fails++; $display("FAIL reset_cnt_data: got %0d/%0d expected 0/0", sample_cnt, out_data);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_full_window();
        meas_t m;
        run_measure(0, 0, 0, m);
        tests_run++;
        if (!m.fin) begin fails++; $display("FAIL full_timeout: got no done expected done"); end
        tests_run++;
        if (m.n_clr != 1) begin fails++; $display("FAIL full_clr_cycles: got %0d expected 1", m.n_clr); end
        tests_run++;
        if (m.n_en != 256) begin fails++; $display("FAIL full_en_cycles: got %0d expected 256", m.n_en); end
        tests_run++;
        if (m.last_en != 257) begin fails++; $display("FAIL full_last_en: got %0d expected 257", m.last_en); end
        tests_run++;
        if (m.first_val != 261) begin fails++; $display("FAIL full_first_valid: got %0d expected 261", m.first_val); end
        tests_run++;
        if (m.nb != 81 || m.gap != 0) begin
            fails++; $display("FAIL full_beats: got %0d beats %0d gaps expected 81/0", m.nb, m.gap);
        end
        tests_run++;
        if (m.data_err != 0) begin fails++; $display("FAIL full_data: got %0d bad beats expected 0", m.data_err); end
        tests_run++;
        if (m.last_err != 0) begin fails++; $display("FAIL full_last: got %0d bad beats expected 0", m.last_err); end
        tests_run++;
        if (m.done_cyc != 342) begin fails++; $display("FAIL full_done_cyc: got %0d expected 342", m.done_cyc); end
        tests_run++;
        if (m.fin_cnt != 256) begin fails++; $display("FAIL full_sample_cnt: got %0d expected 256", m.fin_cnt); end
        @(negedge clk);
        start = 1'b0;
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL full_done_pulse: got done=%b busy=%b expected 0/0", done, busy);
        end
        tests_run++;
        if (sample_cnt !== 16'd256) begin fails++; $display("FAIL full_cnt_hold: got %0d expected 256", sample_cnt); end
    endtask

    task automatic test_toggle_valid();
        meas_t m;
        run_measure(0, 1, 0, m);
        tests_run++;
        if (!m.fin) begin fails++; $display("FAIL toggle_timeout: got no done expected done"); end
        tests_run++;
        if (m.n_en != 256 || m.sv_err != 0) begin
            fails++; $display("FAIL toggle_en: got %0d pulses %0d stray expected 256/0", m.n_en, m.sv_err);
        end
        tests_run++;
        if (m.last_en != 512) begin fails++; $display("FAIL toggle_last_en: got %0d expected 512", m.last_en); end
        tests_run++;
        if (m.first_val != 516 || m.done_cyc != 597) begin
            fails++; $display("FAIL toggle_timing: got %0d/%0d expected 516/597", m.first_val, m.done_cyc);
        end
        tests_run++;
        if (m.data_err != 0) begin fails++; $display("FAIL toggle_data: got %0d bad beats expected 0", m.data_err); end
    endtask

    task automatic test_random_ready();
        meas_t m;
        addr_mode = 1'b1;
        run_measure(1, 0, 0, m);
        addr_mode = 1'b0;
        tests_run++;
        if (!m.fin || m.nb != 81) begin
            fails++; $display("FAIL rand_beats: got fin=%0d beats=%0d expected 1/81", m.fin, m.nb);
        end
        tests_run++;
        if (m.data_err != 0) begin fails++; $display("FAIL rand_order: got %0d bad beats expected 0", m.data_err); end
        tests_run++;
        if (m.last_err != 0) begin fails++; $display("FAIL rand_last: got %0d bad beats expected 0", m.last_err); end
        tests_run++;
        if (m.stab_err != 0) begin fails++; $display("FAIL rand_stall_stable: got %0d changes expected 0", m.stab_err); end
    endtask

    task automatic test_abort();
        meas_t m;
        int done_seen;
        bit hit;
        hit = 0;
        @(negedge clk);
        start = 1'b1; sample_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (sample_cnt == 16'd100) begin hit = 1; break; end
        end
        tests_run++;
        if (!hit) begin fails++; $display("FAIL abort_reach100: got cnt %0d expected 100", sample_cnt); end
        abort = 1'b1;
        #1;
        tests_run++;
        if (acc_en !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL abort_same_cycle: got acc_en=%b expected 0", acc_en);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || acc_en !== 1'b0) begin
            fails++; $display("FAIL abort_idle: got busy=%b acc_en=%b expected 0/0", busy, acc_en);
        end
        tests_run++;
        if (samp_idx != 100 || sample_cnt !== 16'd100) begin
            fails++; $display("FAIL abort_samples: got %0d gated cnt %0d expected 100/100", samp_idx, sample_cnt);
        end
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (done || acc_en) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin fails++; $display("FAIL abort_no_done: got %0d strobes expected 0", done_seen); end
        run_measure(0, 0, 0, m);
        tests_run++;
        if (m.cnt_at_clr != 0 || m.fin_cnt != 256) begin
            fails++; $display("FAIL abort_restart_cnt: got %0d/%0d expected 0/256", m.cnt_at_clr, m.fin_cnt);
        end
        tests_run++;
        if (!m.fin || m.n_en != 256 || m.data_err != 0) begin
            fails++; $display("FAIL abort_rerun: got fin=%0d en=%0d bad=%0d expected 1/256/0",
                              m.fin, m.n_en, m.data_err);
        end
    endtask

    task automatic test_start_in_readout();
        meas_t m;
        int busy_seen;
        run_measure(0, 0, 1, m);
        tests_run++;
        if (!m.fin || m.nb != 81 || m.done_cyc != 342) begin
            fails++; $display("FAIL ro_start_run: got fin=%0d beats=%0d done=%0d expected 1/81/342",
                              m.fin, m.nb, m.done_cyc);
        end
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (busy) busy_seen++;
        end
        tests_run++;
        if (busy_seen != 0) begin fails++; $display("FAIL ro_start_ignored: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        #1;
        tests_run++;
        if (acc_clear !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL idle_abort_now: got clr=%b busy=%b expected 0/0", acc_clear, busy);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || acc_clear !== 1'b0) begin
            fails++; $display("FAIL idle_abort_wins: got busy=%b clr=%b expected 0/0", busy, acc_clear);
        end
    endtask

    task automatic test_rst_mid_readout();
        int nb;
        nb = 0;
        @(negedge clk);
        start = 1'b1; sample_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (out_valid) nb++;
            if (nb == 20) break;
        end
        tests_run++;
        if (nb != 20) begin fails++; $display("FAIL rst_reach_ro: got %0d beats expected 20", nb); end
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({acc_clear, acc_en, out_valid, out_last, busy, done} !== 6'b0) begin
            fails++; $display("FAIL rst_ro_strobes: got %b expected 000000",
                              {acc_clear, acc_en, out_valid, out_last, busy, done});
        end
        tests_run++;
        if ({rd_row, rd_col} !== 8'h00 || sample_cnt !== 16'd0 || out_data !== 9'd0) begin
            fails++; $display("FAIL rst_ro_regs: got addr %h cnt %0d data %0d expected 00/0/0",
                              {rd_row, rd_col}, sample_cnt, out_data);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_ro_release: got busy=%b expected 0", busy); end
    endtask

`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
    task automatic test_sat_flag();
        meas_t m;
        force44 = 1'b1;
        run_measure(0, 0, 0, m);
        force44 = 1'b0;
        tests_run++;
        if (!m.fin || m.sat_done != 1'b1) begin
            fails++; $display("FAIL sat_set: got fin=%0d sat=%0d expected 1/1", m.fin, m.sat_done);
        end
        run_measure(0, 0, 0, m);
        tests_run++;
        if (m.sat_clr != 1'b0) begin fails++; $display("FAIL sat_clear_on_start: got %0d expected 0", m.sat_clr); end
        tests_run++;
        if (!m.fin || m.sat_done != 1'b0) begin
            fails++; $display("FAIL sat_clean_run: got fin=%0d sat=%0d expected 1/0", m.fin, m.sat_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_window();
        test_toggle_valid();
        test_random_ready();
        test_abort();
        test_start_in_readout();
        test_start_abort_idle();
        test_rst_mid_readout();
`ifdef DP_MATRIX_SCHED_SAT_FLAG_EN
        test_sat_flag();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/dp_matrix_scheduler.md
Name: dp_matrix_scheduler

Overview:
Sequences one constellation-histogram measurement on the I/Q matrix accumulator.
- On start: clears the 9x9 matrix, then gates exactly WINDOW_LEN valid samples into it.
- Waits for the input pipeline to flush, then streams all 81 cell counts out row-major over a valid/ready interface.
- Sits between the sample source / host control and the matrix accumulator instance; drives its clear and enable, and its readout row/column select.

Parameters:
- WINDOW_LEN, 256: number of accepted samples per measurement (1..65535).
- MAT_DIM, 9: matrix rows and columns.
- CNT_W, 9: width of one matrix cell counter.
- FLUSH_CYCLES, 2: cycles between the last gated sample and readout, covering input-stage latency (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle request to begin a measurement
- abort  in  1  terminate the current measurement
- sample_valid  in  1  an I/Q sample is present this cycle
- acc_clear  out  1  clear all matrix counters
- acc_en  out  1  forward sample_valid into the accumulator
- rd_row  out  4  readout row select
- rd_col  out  4  readout column select
- cell_data  in  CNT_W  count of cell (rd_row, rd_col); combinational from the accumulator
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the beat
- out_data  out  CNT_W  cell count
- out_last  out  1  marks cell (MAT_DIM-1, MAT_DIM-1)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last beat is accepted
- sample_cnt  out  16  accepted samples in the current window

Interface:
- Single clock, clk.
- Reset rst is synchronous, active-high.

Behaviour:
- Reset: state IDLE; all outputs 0; rd_row/rd_col = 0; sample_cnt = 0.
- IDLE:
  - On start (and no abort), go to CLEAR; sample_cnt <= 0.
  - start is ignored in every other state.
- CLEAR:
  - acc_clear = 1 for exactly one cycle, then go to ACCUM.
- ACCUM:
  - acc_en = sample_valid.
  - Each sample_valid increments sample_cnt.
  - When the sample_valid that brings sample_cnt to WINDOW_LEN is accepted, go to FLUSH next cycle.
  - acc_en is never high for more than WINDOW_LEN samples.
- FLUSH:
  - acc_en = 0.
  - Internal counter runs for FLUSH_CYCLES cycles, then go to READOUT.
  - FLUSH_CYCLES = 0 goes directly to READOUT.
- READOUT:
  - Addresses walk row-major, column fastest: (0,0), (0,1) ... (0,8), (1,0) ... (8,8).
  - The output register loads cell_data at the current (rd_row, rd_col) when !out_valid || out_ready; the address advances on each load.
  - First out_valid is 1 cycle after entering READOUT.
  - Sustained throughput is 1 beat/cycle with out_ready high.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_last = 1 only with the (8,8) beat.
  - After the last beat is accepted: out_valid = 0, go to DONE.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - sample_cnt holds its final value until the next start.
- Abort:
  - Any non-IDLE state goes to IDLE next cycle: out_valid, acc_en, acc_clear drop immediately in that cycle; no done pulse.
  - Matrix contents are untouched.
  - abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- rst asserted mid-operation behaves like reset, regardless of other inputs.
- sample_valid outside ACCUM is ignored; acc_en = 0.
- sample_cnt saturates at WINDOW_LEN.
- busy = (state != IDLE).

Optional Feature:
- Macro: DP_MATRIX_SCHED_SAT_FLAG_EN.
- Defined:
  - Extra output sat_flag (1 bit), cleared on start.
  - Set if any read beat has out_data = 2^CNT_W-1, i.e. a saturated/wrapped-risk cell.
  - Valid from the cycle done pulses until the next start.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package dp_matrix_pkg:
  - state enum (IDLE, CLEAR, ACCUM, FLUSH, READOUT, DONE);
  - MAT_DIM/CNT_W defaults;
  - ADDR_W = 4;
  - NUM_CELLS = MAT_DIM*MAT_DIM.
- One natural sub-module, dp_matrix_rd_walker: row/column address generator with advance, wrap, and last-cell detect.

Test Plan:
- WINDOW_LEN=256, sample_valid always 1, out_ready always 1 -> acc_clear one cycle; acc_en high exactly 256 cycles; FLUSH 2 cycles; 81 consecutive beats; out_last on beat 81; done 1 cycle later; sample_cnt = 256.
- sample_valid toggling 1/0 -> acc_en mirrors it; FLUSH entered after the 256th valid, ~512 cycles; acc_en pulses total 256.
- out_ready random 50% -> 81 beats in order (0,0)..(8,8); out_data stable during stalls; a model matrix matches all beats.
- abort asserted at sample 100 -> IDLE next cycle; acc_en 0; no done; subsequent start runs a full window with sample_cnt restarting at 0.
- start pulsed during READOUT -> ignored; start+abort in IDLE -> stays IDLE; rst mid-READOUT -> all outputs 0 next cycle.
- With DP_MATRIX_SCHED_SAT_FLAG_EN, cell (4,4) forced to 511 -> sat_flag = 1 at done; next start clears it; run with no 511 cells -> 0.
